// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch lap controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        RECALL  = 2'd3
    } state_t;

    localparam int TIME_W  = 24;
    localparam int DIGIT_W = 4;

    // Digit fields inside the time word: {min_h, min_l, sec_h, sec_l, hsec_h, hsec_l}
    localparam int HSEC_L_LSB = 0;
    localparam int HSEC_H_LSB = 4;
    localparam int SEC_L_LSB  = 8;
    localparam int SEC_H_LSB  = 12;
    localparam int MIN_L_LSB  = 16;
    localparam int MIN_H_LSB  = 20;

    localparam int FREEZE_TICKS_DEF = 200;

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_buffer.sv
// Lap register file: sequential writes with a saturating count, clear, and
// a combinational read port.
module lap_buffer #(
    parameter int DEPTH = 4,
    parameter int TW    = 24,
    localparam int IW   = $clog2(DEPTH),
    localparam int CW   = IW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_data,
    input  logic          clr,
    input  logic [IW-1:0] rd_idx,
    output logic [TW-1:0] rd_data,
    output logic [IW-1:0] wptr,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [TW-1:0] mem [DEPTH];
    logic [CW-1:0] count_q;

    // Laps are only ever appended or cleared all at once, so the write
    // pointer is simply the fill count.
    assign wptr    = count_q[IW-1:0];
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH));
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            count_q <= '0;
        end else if (wr_en && !full) begin
            mem[wptr] <= wr_data;
            count_q   <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencing: key decode into counter controls, lap capture with a
// timed display freeze, and lap recall while paused.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH    = 4,
    parameter int FREEZE_TICKS = FREEZE_TICKS_DEF,
    parameter int TW           = TIME_W,
    localparam int IW          = $clog2(LAP_DEPTH),
    localparam int CW          = IW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_s_pressed,
    input  logic          key_r_pressed,
    input  logic          key_l_pressed,
    input  logic          tick_100hz,
    input  logic [TW-1:0] time_bcd,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic [TW-1:0] disp_bcd,
    output logic          disp_is_lap,
    output logic [IW-1:0] lap_idx,
    output logic [CW-1:0] lap_count,
    output logic          lap_full,
    output logic [1:0]    state_o
);

    localparam int FW = $clog2(FREEZE_TICKS + 1);

    state_t        state;
    logic [FW-1:0] freeze_cnt;
    logic [IW-1:0] lap_idx_q;
    logic [IW-1:0] wptr;
    logic [TW-1:0] rd_data;
    logic          buf_wr;
    logic          buf_clr;

    // Keys are one-cycle pulses with no handshake; when several coincide,
    // S beats R beats L and the losers are simply dropped.
    assign buf_wr  = (state == RUNNING) && key_l_pressed && !key_s_pressed && !key_r_pressed;
    assign buf_clr = ((state == PAUSED) || (state == RECALL)) && key_r_pressed && !key_s_pressed;

    lap_buffer #(
        .DEPTH (LAP_DEPTH),
        .TW    (TW)
    ) u_lap_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr),
        .wr_data (time_bcd),
        .clr     (buf_clr),
        .rd_idx  (lap_idx_q),
        .rd_data (rd_data),
        .wptr    (wptr),
        .count   (lap_count),
        .full    (lap_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            freeze_cnt <= '0;
            lap_idx_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    freeze_cnt <= '0;
                    if (key_s_pressed) state <= RUNNING;
                end
                RUNNING: begin
                    if (tick_100hz && freeze_cnt != '0) freeze_cnt <= freeze_cnt - FW'(1);
                    if (key_s_pressed) begin
                        state      <= PAUSED;
                        freeze_cnt <= '0;
                    end else if (buf_wr && !lap_full) begin
                        freeze_cnt <= FW'(FREEZE_TICKS);
                        lap_idx_q  <= wptr;
                    end
                end
                PAUSED: begin
                    freeze_cnt <= '0;
                    if (key_s_pressed) begin
                        state <= RUNNING;
                    end else if (key_r_pressed) begin
                        state     <= IDLE;
                        lap_idx_q <= '0;
                    end else if (key_l_pressed && lap_count != '0) begin
                        state     <= RECALL;
                        lap_idx_q <= '0;
                    end
                end
                RECALL: begin
                    freeze_cnt <= '0;
                    if (key_s_pressed) begin
                        state <= PAUSED;
                    end else if (key_r_pressed) begin
                        state     <= IDLE;
                        lap_idx_q <= '0;
                    end else if (key_l_pressed) begin
                        lap_idx_q <= ({1'b0, lap_idx_q} == lap_count - CW'(1)) ? '0 : lap_idx_q + IW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    freeze_cnt <= '0;
                    lap_idx_q  <= '0;
                end
            endcase
        end
    end

    assign cnt_en      = (state == RUNNING);
    assign cnt_clr     = (state == IDLE);
    assign disp_is_lap = ((state == RUNNING) && freeze_cnt != '0) || (state == RECALL);
    assign disp_bcd    = disp_is_lap ? rd_data : time_bcd;
    assign lap_idx     = lap_idx_q;
    assign state_o     = state;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: expected values are queued as each
// step is driven and popped in order when the outputs are sampled.
module tb_stopwatch_lap_ctrl;

    localparam int LAP_DEPTH    = 4;
    localparam int FREEZE_TICKS = 200;
    localparam int TW           = 24;
    localparam int IW           = 2;
    localparam int CW           = 3;
    localparam int W            = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_s_pressed = 1'b0;
    logic          key_r_pressed = 1'b0;
    logic          key_l_pressed = 1'b0;
    logic          tick_100hz = 1'b0;
    logic [TW-1:0] time_bcd = '0;
    logic          cnt_en;
    logic          cnt_clr;
    logic [TW-1:0] disp_bcd;
    logic          disp_is_lap;
    logic [IW-1:0] lap_idx;
    logic [CW-1:0] lap_count;
    logic          lap_full;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [TW-1:0] laps4 [4];
    logic [TW-1:0] laps3 [3];

    stopwatch_lap_ctrl #(
        .LAP_DEPTH    (LAP_DEPTH),
        .FREEZE_TICKS (FREEZE_TICKS),
        .TW           (TW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_s_pressed (key_s_pressed),
        .key_r_pressed (key_r_pressed),
        .key_l_pressed (key_l_pressed),
        .tick_100hz    (tick_100hz),
        .time_bcd      (time_bcd),
        .cnt_en        (cnt_en),
        .cnt_clr       (cnt_clr),
        .disp_bcd      (disp_bcd),
        .disp_is_lap   (disp_is_lap),
        .lap_idx       (lap_idx),
        .lap_count     (lap_count),
        .lap_full      (lap_full),
        .state_o       (state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // drivers
    task automatic step(input logic s, input logic r, input logic l, input logic t);
        key_s_pressed = s;
        key_r_pressed = r;
        key_l_pressed = l;
        tick_100hz    = t;
        @(posedge clk);
        #1;
        key_s_pressed = 1'b0;
        key_r_pressed = 1'b0;
        key_l_pressed = 1'b0;
        tick_100hz    = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // scoreboard
    task automatic expect_val(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    initial begin
        laps4[0] = 24'h001234;
        laps4[1] = 24'h002000;
        laps4[2] = 24'h003000;
        laps4[3] = 24'h004000;
        laps3[0] = 24'h000100;
        laps3[1] = 24'h000200;
        laps3[2] = 24'h000300;

        time_bcd = 24'h000010;
        #1;
        expect_val(32'd0); expect_val(32'd0); expect_val(32'd1); expect_val(32'h000010);
        expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
        check("rst_state", 32'(state_o));
        check("rst_cnt_en", 32'(cnt_en));
        check("rst_cnt_clr", 32'(cnt_clr));
        check("rst_disp", 32'(disp_bcd));
        check("rst_is_lap", 32'(disp_is_lap));
        check("rst_count", 32'(lap_count));
        check("rst_full", 32'(lap_full));
        check("rst_idx", 32'(lap_idx));

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R and L do nothing in IDLE
        expect_val(32'd0); expect_val(32'd0); expect_val(32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("idle_rl_state", 32'(state_o));
        check("idle_rl_count", 32'(lap_count));
        check("idle_rl_clr", 32'(cnt_clr));

        expect_val(32'd1); expect_val(32'd1); expect_val(32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_state", 32'(state_o));
        check("start_cnt_en", 32'(cnt_en));
        check("start_cnt_clr", 32'(cnt_clr));

        expect_val(32'd1); expect_val(32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("run_r_state", 32'(state_o));
        check("run_r_cnt_en", 32'(cnt_en));

        // first lap and freeze expiry
        time_bcd = 24'h001234;
        expect_val(32'h001234); expect_val(32'd1); expect_val(32'd1); expect_val(32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap1_disp", 32'(disp_bcd));
        check("lap1_is_lap", 32'(disp_is_lap));
        check("lap1_count", 32'(lap_count));
        check("lap1_idx", 32'(lap_idx));

        time_bcd = 24'h001299;
        expect_val(32'h001234); expect_val(32'd1); expect_val(32'd1);
        run_ticks(FREEZE_TICKS - 1);
        check("frz199_disp", 32'(disp_bcd));
        check("frz199_is_lap", 32'(disp_is_lap));
        check("frz199_cnt_en", 32'(cnt_en));

        expect_val(32'h001299); expect_val(32'd0); expect_val(32'd1);
        run_ticks(1);
        check("frz200_disp", 32'(disp_bcd));
        check("frz200_is_lap", 32'(disp_is_lap));
        check("frz200_cnt_en", 32'(cnt_en));

        // fill the buffer
        for (int i = 1; i < 4; i++) begin
            time_bcd = laps4[i];
            expect_val(32'(laps4[i])); expect_val(32'd1); expect_val(32'(i + 1)); expect_val(32'(i));
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("fill_disp", 32'(disp_bcd));
            check("fill_is_lap", 32'(disp_is_lap));
            check("fill_count", 32'(lap_count));
            check("fill_idx", 32'(lap_idx));
        end
        expect_val(32'd1);
        check("fill_full", 32'(lap_full));

        // lap attempt with a full buffer: no write, no freeze
        run_ticks(FREEZE_TICKS);
        time_bcd = 24'h005000;
        expect_val(32'd0); expect_val(32'h005000); expect_val(32'd4); expect_val(32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("full_is_lap", 32'(disp_is_lap));
        check("full_disp", 32'(disp_bcd));
        check("full_count", 32'(lap_count));
        check("full_full", 32'(lap_full));

        // pause and recall all four laps, wrapping once
        expect_val(32'd2); expect_val(32'd0); expect_val(32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_state", 32'(state_o));
        check("pause_cnt_en", 32'(cnt_en));
        check("pause_is_lap", 32'(disp_is_lap));

        for (int i = 0; i < 5; i++) begin
            expect_val(32'd3); expect_val(32'(i % 4)); expect_val(32'(laps4[i % 4]));
            expect_val(32'd1); expect_val(32'd0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("rcl4_state", 32'(state_o));
            check("rcl4_idx", 32'(lap_idx));
            check("rcl4_disp", 32'(disp_bcd));
            check("rcl4_is_lap", 32'(disp_is_lap));
            check("rcl4_cnt_en", 32'(cnt_en));
        end

        expect_val(32'd2); expect_val(32'd0); expect_val(32'h005000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rcl_exit_state", 32'(state_o));
        check("rcl_exit_is_lap", 32'(disp_is_lap));
        check("rcl_exit_disp", 32'(disp_bcd));

        // S beats R in PAUSED
        expect_val(32'd1); expect_val(32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("sr_state", 32'(state_o));
        check("sr_count", 32'(lap_count));

        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_val(32'd0); expect_val(32'd0); expect_val(32'd1); expect_val(32'd0); expect_val(32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("clr_state", 32'(state_o));
        check("clr_count", 32'(lap_count));
        check("clr_cnt_clr", 32'(cnt_clr));
        check("clr_full", 32'(lap_full));
        check("clr_idx", 32'(lap_idx));

        // L with no laps stays PAUSED
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_val(32'd2); expect_val(32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("nolap_state", 32'(state_o));
        check("nolap_is_lap", 32'(disp_is_lap));

        // three laps, then S+L: S wins
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            time_bcd = laps3[i];
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        time_bcd = 24'h000399;
        expect_val(32'd2); expect_val(32'd3); expect_val(32'd0); expect_val(32'h000399);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("sl_state", 32'(state_o));
        check("sl_count", 32'(lap_count));
        check("sl_is_lap", 32'(disp_is_lap));
        check("sl_disp", 32'(disp_bcd));

        for (int i = 0; i < 4; i++) begin
            expect_val(32'(i % 3)); expect_val(32'(laps3[i % 3]));
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("rcl3_idx", 32'(lap_idx));
            check("rcl3_disp", 32'(disp_bcd));
        end

        // asynchronous reset in RECALL
        #2;
        rst_n = 1'b0;
        #1;
        expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd1); expect_val(32'd0);
        check("arst_rcl_state", 32'(state_o));
        check("arst_rcl_count", 32'(lap_count));
        check("arst_rcl_is_lap", 32'(disp_is_lap));
        check("arst_rcl_cnt_clr", 32'(cnt_clr));
        check("arst_rcl_idx", 32'(lap_idx));
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // asynchronous reset during freeze
        step(1'b1, 1'b0, 1'b0, 1'b0);
        time_bcd = 24'h000777;
        expect_val(32'd1); expect_val(32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("frz2_is_lap", 32'(disp_is_lap));
        check("frz2_count", 32'(lap_count));
        #2;
        rst_n = 1'b0;
        #1;
        expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
        check("arst_frz_state", 32'(state_o));
        check("arst_frz_count", 32'(lap_count));
        check("arst_frz_is_lap", 32'(disp_is_lap));
        check("arst_frz_cnt_en", 32'(cnt_en));
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // freeze must not survive the reset
        time_bcd = 24'h000800;
        expect_val(32'd1); expect_val(32'd0); expect_val(32'h000800);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_state", 32'(state_o));
        check("post_rst_is_lap", 32'(disp_is_lap));
        check("post_rst_disp", 32'(disp_bcd));

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Sequencing controller for the BCD stopwatch timebase: decodes the debounced start/stop, reset and lap key pulses into count-enable and clear controls for the time counter. It captures up to LAP_DEPTH split times into an internal lap buffer and drives the 24-bit BCD value shown on the six-digit display. The display shows one of three sources: live time, a frozen lap for a fixed period, or a recalled lap. It sits between the key debouncer/edge detectors and the time counter/SEG7_LUT display chain.

Parameters:
LAP_DEPTH, 4, number of lap registers (2..8); lap_count width is clog2(LAP_DEPTH)+1.
FREEZE_TICKS, 200, number of tick_100hz pulses a freshly captured lap stays on the display (2 s at 100 Hz).
TW, 24, time word width: six BCD digits, {min_h, min_l, sec_h, sec_l, hsec_h, hsec_l}.

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
key_s_pressed  in  1  one-cycle start/stop pulse
key_r_pressed  in  1  one-cycle reset pulse
key_l_pressed  in  1  one-cycle lap/recall pulse
tick_100hz  in  1  one-cycle 100 Hz enable, shared with the time counter
time_bcd  in  TW  live time from the counter
cnt_en  out  1  counter run enable
cnt_clr  out  1  counter synchronous clear
disp_bcd  out  TW  value to display decoders
disp_is_lap  out  1  1 when disp_bcd is a stored lap
lap_idx  out  clog2(LAP_DEPTH)  index of the lap displayed
lap_count  out  clog2(LAP_DEPTH)+1  laps stored
lap_full  out  1  lap_count == LAP_DEPTH
state_o  out  2  current state, for debug/LEDs

Behaviour:
- One clock domain. All registers reset asynchronously on rst_n low. Reset values: state IDLE, lap_count 0, write pointer 0, lap_idx 0, freeze counter 0, all lap registers 0.
- After reset the outputs are: cnt_en=0, cnt_clr=1, disp_bcd=time_bcd, disp_is_lap=0, lap_full=0, state_o=IDLE.
- States (encoding in package): IDLE=0, RUNNING=1, PAUSED=2, RECALL=3.
- Outputs are Moore, decoded from the state register:
  - cnt_en = (state==RUNNING).
  - cnt_clr = (state==IDLE).
- Key priority when pulses coincide in the same cycle: S > R > L. Only the winning key acts; the others are dropped.
- IDLE:
  - S -> RUNNING. cnt_en rises on the cycle after the pulse.
  - R and L are ignored.
- RUNNING:
  - S -> PAUSED.
  - R is ignored (no reset while timing).
  - L with lap_count<LAP_DEPTH: lap[wptr] <= time_bcd sampled on the pulse edge; wptr++, lap_count++; freeze counter loads FREEZE_TICKS.
  - L with lap_full: no write, no freeze; state unchanged.
- Freeze:
  - While the freeze counter is nonzero and state==RUNNING: disp_bcd = last captured lap, disp_is_lap=1, lap_idx = index of that lap.
  - The counter decrements on each tick_100hz.
  - A new L capture reloads the counter.
  - Leaving RUNNING clears the counter.
  - The time counter keeps running during freeze (cnt_en stays 1).
- PAUSED:
  - S -> RUNNING.
  - R -> IDLE; lap_count, wptr and lap_idx clear on the same edge. Lap data need not be cleared.
  - L with lap_count>0 -> RECALL with lap_idx=0.
  - L with lap_count==0 is ignored.
- RECALL:
  - disp_bcd = lap[lap_idx], disp_is_lap=1.
  - L: lap_idx increments and wraps to 0 after lap_count-1.
  - S -> PAUSED; display returns to live.
  - R -> IDLE and clears the laps.
  - cnt_en=0 throughout.
- Otherwise disp_bcd = time_bcd (combinational pass-through), disp_is_lap=0.
- Display latency: lap/freeze outputs are valid the cycle after the triggering pulse.
- Illegal state encodings fall to IDLE.
- Reset mid-operation (rst_n low in any state) returns immediately to the reset values; no lap data survives.

Decomposition:
- Package stopwatch_pkg:
  - state localparams IDLE/RUNNING/PAUSED/RECALL;
  - TW and the BCD digit width (4);
  - digit field offsets within time_bcd;
  - FREEZE_TICKS default.
- Sub-module lap_buffer: LAP_DEPTH x TW register file with write enable, write pointer, saturating count, clear, and combinational read mux by index.
- The FSM, freeze counter and display mux remain in stopwatch_lap_ctrl.

Test Plan:
1. Reset, then S pulse -> cnt_clr 1->0 and cnt_en 0->1 one cycle after the pulse. R pulse while RUNNING -> no change.
2. RUNNING, time_bcd=24'h001234, L pulse -> next cycle disp_bcd=24'h001234, disp_is_lap=1, lap_count=1. After 200 tick_100hz pulses -> disp_bcd tracks time_bcd again. cnt_en stays 1 throughout.
3. Five L pulses in RUNNING with LAP_DEPTH=4 -> lap_count=4, lap_full=1. The fifth pulse loads no freeze and leaves lap[0..3] unchanged.
4. PAUSED with 3 laps, L x4 -> lap_idx 0,1,2,0 with disp_bcd equal to the stored laps. S -> PAUSED, disp_is_lap=0.
5. PAUSED, S and R asserted in the same cycle -> RUNNING, lap_count unchanged. Separate R -> IDLE, lap_count=0, cnt_clr=1.
6. rst_n pulled low during RECALL and freeze -> asynchronous return to IDLE and lap_count=0 without a clock edge.
